// File: rtl/if_prefetch.sv
// Instruction-fetch prefetcher: keeps a small FIFO of fetched words ahead of decode,
// issuing one ROM request at a time and discarding results made stale by a jump.
module if_prefetch #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    output logic              rom_req_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic              rom_ack_i,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic              ins_valid_o,
    output logic [DATA_W-1:0] ins_o,
    output logic [ADDR_W-1:0] ins_addr_o,
    input  logic              id_ready_i
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_DROP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              gap_q, gap_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              req;
    logic              push;
    logic              pop;

    logic [DATA_W-1:0] data_mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_mem_q [DEPTH];

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        req_addr_d = req_addr_q;
        gap_d      = 1'b0;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        req        = 1'b0;
        push       = 1'b0;

        case (state_q)
            S_RUN: begin
                // gap_q enforces an idle cycle after a same-cycle ack, capping throughput at one fetch per two cycles
                req = !jump_flag_i && !gap_q && (cnt_q < CNT_W'(DEPTH));
                if (req) begin
                    if (rom_ack_i) begin
                        push  = 1'b1;
                        gap_d = 1'b1;
                    end else begin
                        state_d    = S_WAIT;
                        req_addr_d = fpc_q;
                    end
                end
            end
            S_WAIT: begin
                req = 1'b1;
                if (rom_ack_i) begin
                    state_d = S_RUN;
                    push    = !jump_flag_i;
                end else if (jump_flag_i) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                req = 1'b1;
                if (rom_ack_i) state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase

        pop = (cnt_q != '0) && id_ready_i && !jump_flag_i;

        if (jump_flag_i) begin
            fpc_d    = jump_addr_i;
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                fpc_d    = fpc_q + ADDR_W'(PC_STEP);
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_RUN;
            fpc_q      <= RESET_PC;
            req_addr_q <= RESET_PC;
            gap_q      <= 1'b0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            req_addr_q <= req_addr_d;
            gap_q      <= gap_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst && !jump_flag_i) begin
            data_mem_q[wr_ptr_q] <= rom_data_i;
            addr_mem_q[wr_ptr_q] <= fpc_q;
        end
    end

    // While a stale request is in flight the ROM keeps seeing the original address, not the new target
    assign rom_addr_o  = (state_q == S_RUN) ? fpc_q : req_addr_q;
    assign rom_req_o   = req && !rst;
    assign ins_valid_o = (cnt_q != '0);
    assign ins_o       = data_mem_q[rd_ptr_q];
    assign ins_addr_o  = addr_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: sequential fetch, buffer fill, jump/drop, wrap and reset cases.
module tb_if_prefetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        rom_ack;
    logic [31:0] rom_data;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_addr;
    logic        id_ready;

    logic        auto_ack;
    logic        man_ack;
    logic [31:0] man_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Auto mode: ROM acks in the same cycle as the request with data = addr + 0x1000_0000
    assign rom_ack  = auto_ack ? rom_req : man_ack;
    assign rom_data = auto_ack ? (rom_addr + 32'h1000_0000) : man_data;

    if_prefetch dut (
        .clk        (clk),
        .rst        (rst),
        .jump_flag_i(jump_flag),
        .jump_addr_i(jump_addr),
        .rom_req_o  (rom_req),
        .rom_addr_o (rom_addr),
        .rom_ack_i  (rom_ack),
        .rom_data_i (rom_data),
        .ins_valid_o(ins_valid),
        .ins_o      (ins),
        .ins_addr_o (ins_addr),
        .id_ready_i (id_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; auto_ack = 1'b0; man_ack = 1'b0; man_data = '0;
        jump_flag = 1'b0; jump_addr = '0; id_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; auto_ack = 1'b0; man_ack = 1'b1; man_data = '0;
        jump_flag = 1'b0; jump_addr = '0; id_ready = 1'b0;
        step(); step();
        #1;
        checks++;
        if (rom_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", rom_req); end
        checks++;
        if (ins_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", ins_valid); end
        man_ack = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 32'h0) begin
            failures++; $display("FAIL reset_first_req req=%b addr=%h exp req=1 addr=0", rom_req, rom_addr);
        end
        $display("test_reset: first request addr=%h", rom_addr);
    endtask

    task automatic test_sequential();
        apply_reset();
        auto_ack = 1'b1; id_ready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rom_req !== 1'b1 || rom_addr !== 32'(k * 4)) begin
                failures++; $display("FAIL seq_req k=%0d req=%b addr=%h exp req=1 addr=%h", k, rom_req, rom_addr, 32'(k * 4));
            end
            step();
            checks++;
            if (rom_req !== 1'b0 || ins_valid !== 1'b1 || ins_addr !== 32'(k * 4) || ins !== 32'(k * 4) + 32'h1000_0000) begin
                failures++;
                $display("FAIL seq_head k=%0d req=%b valid=%b addr=%h ins=%h exp req=0 valid=1 addr=%h ins=%h",
                         k, rom_req, ins_valid, ins_addr, ins, 32'(k * 4), 32'(k * 4) + 32'h1000_0000);
            end
            $display("test_sequential: fetched addr=%h ins=%h", ins_addr, ins);
            step();
        end
    endtask

    task automatic test_fill();
        int acks;
        apply_reset();
        auto_ack = 1'b1; id_ready = 1'b0;
        acks = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (rom_req && rom_ack) acks++;
            step();
        end
        checks++;
        if (acks != 4) begin failures++; $display("FAIL fill_acks got=%0d exp=4", acks); end
        checks++;
        if (rom_req !== 1'b0 || ins_valid !== 1'b1 || ins_addr !== 32'h0) begin
            failures++; $display("FAIL fill_full req=%b valid=%b head=%h exp req=0 valid=1 head=0", rom_req, ins_valid, ins_addr);
        end
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        #1;
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 32'h10 || ins_addr !== 32'h4) begin
            failures++; $display("FAIL fill_refill req=%b addr=%h head=%h exp req=1 addr=10 head=4", rom_req, rom_addr, ins_addr);
        end
        $display("test_fill: acks=%0d refill addr=%h", acks, rom_addr);
        auto_ack = 1'b0;
    endtask

    task automatic test_jump_drop();
        apply_reset();
        id_ready = 1'b1;
        jump_flag = 1'b1; jump_addr = 32'h8;
        #1;
        checks++;
        if (rom_req !== 1'b0) begin failures++; $display("FAIL jrun_req got=%b exp=0", rom_req); end
        step();
        jump_flag = 1'b0;
        #1;
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 32'h8) begin
            failures++; $display("FAIL jrun_target req=%b addr=%h exp req=1 addr=8", rom_req, rom_addr);
        end
        step();
        jump_flag = 1'b1; jump_addr = 32'h100;
        step();
        jump_flag = 1'b0;
        #1;
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 32'h8 || ins_valid !== 1'b0) begin
            failures++; $display("FAIL drop_hold req=%b addr=%h valid=%b exp req=1 addr=8 valid=0", rom_req, rom_addr, ins_valid);
        end
        man_ack = 1'b1; man_data = 32'hBAD0_0008;
        step();
        man_ack = 1'b0;
        #1;
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 32'h100 || ins_valid !== 1'b0) begin
            failures++; $display("FAIL drop_next req=%b addr=%h valid=%b exp req=1 addr=100 valid=0", rom_req, rom_addr, ins_valid);
        end
        man_ack = 1'b1; man_data = 32'hDEAD_0100;
        step();
        man_ack = 1'b0;
        #1;
        checks++;
        if (ins_valid !== 1'b1 || ins_addr !== 32'h100 || ins !== 32'hDEAD_0100) begin
            failures++; $display("FAIL drop_push valid=%b addr=%h ins=%h exp valid=1 addr=100 ins=dead0100", ins_valid, ins_addr, ins);
        end
        $display("test_jump_drop: head addr=%h ins=%h", ins_addr, ins);
    endtask

    task automatic test_jump_ack_pop();
        apply_reset();
        auto_ack = 1'b1; id_ready = 1'b0;
        step(); step(); step(); step();
        auto_ack = 1'b0; man_ack = 1'b0;
        step();
        jump_flag = 1'b1; jump_addr = 32'h200; man_ack = 1'b1; man_data = 32'h5555_0008; id_ready = 1'b1;
        #1;
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 32'h8 || ins_valid !== 1'b1 || ins_addr !== 32'h0) begin
            failures++; $display("FAIL jap_pre req=%b addr=%h valid=%b head=%h exp req=1 addr=8 valid=1 head=0", rom_req, rom_addr, ins_valid, ins_addr);
        end
        step();
        jump_flag = 1'b0; man_ack = 1'b0; id_ready = 1'b0;
        #1;
        checks++;
        if (ins_valid !== 1'b0 || rom_req !== 1'b1 || rom_addr !== 32'h200) begin
            failures++; $display("FAIL jap_post valid=%b req=%b addr=%h exp valid=0 req=1 addr=200", ins_valid, rom_req, rom_addr);
        end
        $display("test_jump_ack_pop: next addr=%h", rom_addr);
    endtask

    task automatic test_wrap();
        apply_reset();
        id_ready = 1'b0;
        jump_flag = 1'b1; jump_addr = 32'hFFFF_FFFC;
        step();
        jump_flag = 1'b0; auto_ack = 1'b1;
        step();
        checks++;
        if (ins_valid !== 1'b1 || ins_addr !== 32'hFFFF_FFFC || ins !== 32'h0FFF_FFFC) begin
            failures++; $display("FAIL wrap_head valid=%b addr=%h ins=%h exp valid=1 addr=fffffffc ins=0ffffffc", ins_valid, ins_addr, ins);
        end
        step();
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 32'h0) begin
            failures++; $display("FAIL wrap_fpc req=%b addr=%h exp req=1 addr=0", rom_req, rom_addr);
        end
        $display("test_wrap: after wrap addr=%h", rom_addr);
        auto_ack = 1'b0;
    endtask

    task automatic test_reset_wait();
        apply_reset();
        id_ready = 1'b0;
        jump_flag = 1'b1; jump_addr = 32'h40;
        step();
        jump_flag = 1'b0;
        step();
        rst = 1'b1; man_ack = 1'b1; man_data = 32'h7777_0040;
        step();
        man_ack = 1'b0;
        #1;
        checks++;
        if (rom_req !== 1'b0 || ins_valid !== 1'b0) begin
            failures++; $display("FAIL rstwait_out req=%b valid=%b exp req=0 valid=0", rom_req, ins_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rom_req !== 1'b1 || rom_addr !== 32'h0) begin
            failures++; $display("FAIL rstwait_pc req=%b addr=%h exp req=1 addr=0", rom_req, rom_addr);
        end
        $display("test_reset_wait: restart addr=%h", rom_addr);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_fill();
        test_jump_drop();
        test_jump_ack_pop();
        test_wrap();
        test_reset_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
